// File: rtl/gshare_predictor_pkg.sv
// Shared constants for the gshare branch predictor: counter encodings, FSM states, default widths.
// No logic; constants only.
// Not applicable: no flow control.
package gshare_predictor_pkg;

    localparam int PC_W_DEF  = 64;
    localparam int IDX_W_DEF = 8;
    localparam int GHR_W_DEF = 8;

    // 2-bit saturating counter encodings; the MSB is the predicted direction
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
// Latency: combinational.
// Backpressure: none.
module bp_sat_ctr
    import gshare_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit counters.
// Latency: prediction one cycle after pred_valid; updates take effect the same cycle (write-first).
// Backpressure: none; all requests are ignored while the init sweep runs (init_busy=1).
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int         PC_W     = PC_W_DEF,
    parameter int         IDX_W    = IDX_W_DEF,
    parameter int         GHR_W    = GHR_W_DEF,
    parameter logic [1:0] CTR_INIT = CTR_WNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_resp_valid,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_mispredict,
    output logic             init_busy
);

    localparam int DEPTH = 1 << IDX_W;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
    logic [GHR_W-1:0]   ghr_q;
    logic [1:0]         pht [DEPTH];

    logic               pred_acc, upd_acc;
    logic [IDX_W-1:0]   pred_idx, upd_idx;
    logic [1:0]         upd_ctr, upd_ctr_next, lookup_ctr;
    logic [GHR_W-1:0]   ghr_spec, ghr_repair;
    logic               pht_we;
    logic [IDX_W-1:0]   pht_wa;
    logic [1:0]         pht_wd;
    logic               unused_bits;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        init_busy  = 1'b0;
        pred_acc   = 1'b0;
        upd_acc    = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_busy  = 1'b1;
                init_ptr_d = init_ptr_q + IDX_W'(1);
                if (init_ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN: begin
                pred_acc = pred_valid;
                upd_acc  = upd_valid;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign upd_idx  = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);
    assign upd_ctr  = pht[upd_idx];

    bp_sat_ctr u_sat_ctr (
        .ctr      (upd_ctr),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    // Same-cycle update to the looked-up entry must be visible to the lookup
    assign lookup_ctr = (upd_acc && (upd_idx == pred_idx)) ? upd_ctr_next : pht[pred_idx];

    // The sweep owns the single write port during INIT
    always_comb begin
        pht_we = 1'b0;
        pht_wa = upd_idx;
        pht_wd = upd_ctr_next;
        if (state_q == ST_INIT) begin
            pht_we = 1'b1;
            pht_wa = init_ptr_q;
            pht_wd = CTR_INIT;
        end else if (upd_acc) begin
            pht_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (pht_we) pht[pht_wa] <= pht_wd;
    end

    // Truncating casts drop the oldest history bit; also valid for GHR_W == 1
    assign ghr_spec   = GHR_W'({ghr_q, lookup_ctr[1]});
    assign ghr_repair = GHR_W'({upd_ghr, upd_taken});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (upd_acc && upd_mispredict) begin
            ghr_q <= ghr_repair;
        end else if (pred_acc) begin
            ghr_q <= ghr_spec;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
            pred_ghr        <= '0;
        end else begin
            pred_resp_valid <= pred_acc;
            if (pred_acc) begin
                pred_taken <= lookup_ctr[1];
                pred_ghr   <= ghr_q;
            end
        end
    end

    assign unused_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                           upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0], lookup_ctr[0]};

endmodule
